// File: rtl/status_array_flush_engine.sv
// status_array_flush_engine
// Initializes every row of a status array after reset. Afterwards it serves
// run-time flush requests over an inclusive row range with a per-block write
// mask. All state holds while the downstream stall input i_halt is high.
module status_array_flush_engine #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    ROW_WIDTH  = 8,
    parameter int                    NUM_BLOCKS = 4,
    parameter logic [ROW_WIDTH-1:0]  INIT_VALUE = {ROW_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_flush_req,
    input  logic [ADDR_WIDTH-1:0] i_flush_start,
    input  logic [ADDR_WIDTH-1:0] i_flush_end,
    input  logic [NUM_BLOCKS-1:0] i_flush_mask,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic                  o_valid,
    output logic                  o_init_complete,
    output logic                  o_ready,
    output logic                  o_flush_done,
    output logic                  o_flush_err
);

    typedef enum logic [1:0] {
        S_UNINIT = 2'd0,
        S_INIT   = 2'd1,
        S_FLUSH  = 2'd2,
        S_IDLE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [NUM_BLOCKS-1:0] r_mask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ROW_WIDTH-1:0]  r_data;
    logic [NUM_BLOCKS-1:0] r_wmask;
    logic                  r_valid;
    logic                  r_init_complete;
    logic                  r_from_flush;
    logic                  r_flush_done;
    logic                  r_flush_err;

    logic                  w_ready;
    logic                  w_last;
    logic                  w_range_ok;

    // A request can only be taken once the last write has drained and
    // the downstream is not stalling.
    assign w_ready    = (r_state == S_IDLE) && !r_valid && !i_halt;
    // Equality test before incrementing lets the range end at the top row
    // without the counter ever wrapping.
    assign w_last     = (r_cnt == r_end);
    assign w_range_ok = (i_flush_start <= i_flush_end);

    // Walk/flush sequencer with registered write-port outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state         <= S_UNINIT;
            r_cnt           <= '0;
            r_end           <= '0;
            r_mask          <= '0;
            r_addr          <= '0;
            r_data          <= '0;
            r_wmask         <= '0;
            r_valid         <= 1'b0;
            r_init_complete <= 1'b0;
            r_from_flush    <= 1'b0;
            r_flush_done    <= 1'b0;
            r_flush_err     <= 1'b0;
        end else if (!i_halt) begin
            // Pulses last exactly one unstalled cycle.
            r_flush_done <= 1'b0;
            r_flush_err  <= 1'b0;
            case (r_state)
                S_UNINIT: begin
                    // Power-on walk covers the whole array with all blocks.
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                    r_end   <= '1;
                    r_mask  <= '1;
                end
                S_INIT, S_FLUSH: begin
                    r_addr  <= r_cnt;
                    r_wmask <= r_mask;
                    r_data  <= INIT_VALUE;
                    r_valid <= 1'b1;
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_from_flush <= (r_state == S_FLUSH);
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_IDLE: begin
                    if (r_valid) begin
                        // Drain the final write; only a flush reports done.
                        r_addr          <= '0;
                        r_data          <= '0;
                        r_wmask         <= '0;
                        r_valid         <= 1'b0;
                        r_flush_done    <= r_from_flush;
                        r_from_flush    <= 1'b0;
                        r_init_complete <= 1'b1;
                    end else if (i_flush_req) begin
                        if (w_range_ok) begin
                            r_cnt   <= i_flush_start;
                            r_end   <= i_flush_end;
                            r_mask  <= i_flush_mask;
                            r_state <= S_FLUSH;
                        end else begin
                            r_flush_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_UNINIT;
            endcase
        end
    end

    assign o_addr          = r_addr;
    assign o_data          = r_data;
    assign o_wen           = r_valid;
    assign o_wmask         = r_wmask;
    assign o_valid         = r_valid;
    assign o_init_complete = r_init_complete;
    assign o_ready         = w_ready;
    assign o_flush_done    = r_flush_done;
    assign o_flush_err     = r_flush_err;

endmodule

// File: tb/tb_status_array_flush_engine.sv
// Testbench for status_array_flush_engine: expected writes are queued when
// stimulus is applied and checked as the DUT presents them.
module tb_status_array_flush_engine;

    localparam int               AW = 4;
    localparam int               RW = 8;
    localparam int               NB = 4;
    localparam logic [RW-1:0]    IV = 8'hA5;

    logic          clk;
    logic          arst_n;
    logic          i_halt;
    logic          i_flush_req;
    logic [AW-1:0] i_flush_start;
    logic [AW-1:0] i_flush_end;
    logic [NB-1:0] i_flush_mask;
    logic [AW-1:0] o_addr;
    logic [RW-1:0] o_data;
    logic          o_wen;
    logic [NB-1:0] o_wmask;
    logic          o_valid;
    logic          o_init_complete;
    logic          o_ready;
    logic          o_flush_done;
    logic          o_flush_err;

    status_array_flush_engine #(
        .ADDR_WIDTH(AW),
        .ROW_WIDTH (RW),
        .NUM_BLOCKS(NB),
        .INIT_VALUE(IV)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_halt         (i_halt),
        .i_flush_req    (i_flush_req),
        .i_flush_start  (i_flush_start),
        .i_flush_end    (i_flush_end),
        .i_flush_mask   (i_flush_mask),
        .o_addr         (o_addr),
        .o_data         (o_data),
        .o_wen          (o_wen),
        .o_wmask        (o_wmask),
        .o_valid        (o_valid),
        .o_init_complete(o_init_complete),
        .o_ready        (o_ready),
        .o_flush_done   (o_flush_done),
        .o_flush_err    (o_flush_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [NB-1:0] mask;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks;
    int  n_errors;
    int  done_cnt;
    int  err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int s, input int e, input logic [NB-1:0] m);
        wr_t w;
        for (int a = s; a <= e; a++) begin
            w.addr = a[AW-1:0];
            w.mask = m;
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({o_addr, o_data, o_wen, o_wmask, o_valid, o_init_complete,
                    o_ready, o_flush_done, o_flush_err});
    endfunction

    // Scoreboard: a write is consumed at the end of a valid, unstalled cycle.
    always @(negedge clk) begin
        if (arst_n && !i_halt) begin
            if (o_flush_done) done_cnt++;
            if (o_flush_err)  err_cnt++;
            if (o_valid) begin
                check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    $display("write addr=%0d wmask=%0h data=%0h", o_addr, o_wmask, o_data);
                    check_val("wr_addr",  32'(o_addr),  32'(mon_e.addr));
                    check_val("wr_wmask", 32'(o_wmask), 32'(mon_e.mask));
                    check_val("wr_data",  32'(o_data),  32'(IV));
                    check_val("wr_wen",   32'(o_wen),   32'd1);
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int  guard;
        guard = 0;
        while (!(o_ready && exp_q.size() == 0) && guard < 300) begin
            tick();
            guard++;
        end
        check_val(tag, 32'(guard >= 300), 32'd0);
    endtask

    // Issue one request from a cycle where o_ready is high and follow it through.
    task automatic do_flush(input int s, input int e, input logic [NB-1:0] m);
        int  d0;
        int  e0;
        int  nvalid;
        int  guard;
        bit  ok;
        d0 = done_cnt;
        e0 = err_cnt;
        ok = (s <= e);
        $display("flush request start=%0d end=%0d mask=%0h", s, e, m);
        check_val("ready_before_req", 32'(o_ready), 32'd1);
        i_flush_req   = 1'b1;
        i_flush_start = s[AW-1:0];
        i_flush_end   = e[AW-1:0];
        i_flush_mask  = m;
        if (ok) push_range(s, e, m);
        tick();
        // Later input changes must not affect the accepted request.
        i_flush_req   = 1'b0;
        i_flush_start = ~s[AW-1:0];
        i_flush_end   = ~e[AW-1:0];
        i_flush_mask  = ~m;
        check_val("lat_c1_valid", 32'(o_valid), 32'd0);
        if (!ok) begin
            check_val("err_pulse", 32'(o_flush_err), 32'd1);
            check_val("err_ready", 32'(o_ready), 32'd1);
            tick();
            check_val("err_pulse_end", 32'(o_flush_err), 32'd0);
            check_val("err_no_write",  32'(o_valid), 32'd0);
            check_val("err_count",     32'(err_cnt - e0), 32'd1);
            check_val("err_no_done",   32'(done_cnt - d0), 32'd0);
            return;
        end
        tick();
        check_val("lat_c2_valid", 32'(o_valid), 32'd1);
        check_val("lat_c2_addr",  32'(o_addr), 32'(s));
        nvalid = 0;
        guard  = 0;
        while (o_valid && guard < 200) begin
            nvalid++;
            tick();
            guard++;
        end
        check_val("flush_nvalid", 32'(nvalid), 32'(e - s + 1));
        check_val("done_pulse",   32'(o_flush_done), 32'd1);
        tick();
        check_val("done_pulse_end", 32'(o_flush_done), 32'd0);
        check_val("ready_after",    32'(o_ready), 32'd1);
        check_val("sb_drained",     32'(exp_q.size()), 32'd0);
        check_val("done_count",     32'(done_cnt - d0), 32'd1);
        check_val("flush_no_err",   32'(err_cnt - e0), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int guard;
        int d0;
        int accepts;
        bit seen_ic;

        n_checks = 0; n_errors = 0; done_cnt = 0; err_cnt = 0;
        arst_n = 1'b0; i_halt = 1'b0; i_flush_req = 1'b0;
        i_flush_start = '0; i_flush_end = '0; i_flush_mask = '0;

        // Reset state and power-on walk.
        repeat (3) tick();
        check_val("reset_outputs", all_outputs(), 32'd0);
        push_range(0, 15, 4'hF);
        arst_n = 1'b1;
        tick();
        check_val("uninit_no_write", 32'(o_valid), 32'd0);
        tick();
        check_val("init_first_valid", 32'(o_valid), 32'd1);
        check_val("init_first_addr",  32'(o_addr), 32'd0);

        // Stall the walk at row 5.
        guard = 0;
        while (!(o_valid && o_addr == 4'd5) && guard < 50) begin
            tick();
            guard++;
        end
        check_val("reach_addr5", 32'(guard >= 50), 32'd0);
        i_halt = 1'b1;
        #1;
        check_val("halt_ready_low", 32'(o_ready), 32'd0);
        repeat (3) begin
            tick();
            check_val("halt_addr",  32'(o_addr), 32'd5);
            check_val("halt_valid", 32'(o_valid), 32'd1);
        end
        i_halt = 1'b0;

        guard = 0;
        while (!(o_valid && o_addr == 4'd15) && guard < 50) begin
            tick();
            guard++;
        end
        check_val("reach_addr15", 32'(guard >= 50), 32'd0);
        check_val("ic_before_drain", 32'(o_init_complete), 32'd0);
        tick();
        check_val("init_drain_valid", 32'(o_valid), 32'd0);
        check_val("init_complete",    32'(o_init_complete), 32'd1);
        check_val("init_ready",       32'(o_ready), 32'd1);
        check_val("init_no_done",     32'(done_cnt), 32'd0);
        check_val("init_sb_drained",  32'(exp_q.size()), 32'd0);

        // Idle stall removes readiness combinationally.
        i_halt = 1'b1;
        #1;
        check_val("idle_halt_ready", 32'(o_ready), 32'd0);
        i_halt = 1'b0;
        #1;
        check_val("idle_unhalt_ready", 32'(o_ready), 32'd1);

        // Run-time flushes.
        do_flush(3, 5, 4'b0101);
        do_flush(9, 2, 4'hF);
        do_flush(15, 15, 4'hA);
        do_flush(0, 1, 4'h0);
        do_flush(0, 15, 4'h3);

        // Reset in the middle of a flush over 4..12.
        d0 = done_cnt;
        $display("flush request start=4 end=12 mask=f (interrupted)");
        i_flush_req = 1'b1; i_flush_start = 4'd4; i_flush_end = 4'd12; i_flush_mask = 4'hF;
        push_range(4, 12, 4'hF);
        tick();
        i_flush_req = 1'b0;
        guard = 0;
        while (!(o_valid && o_addr == 4'd7) && guard < 50) begin
            tick();
            guard++;
        end
        check_val("reach_flush_addr7", 32'(guard >= 50), 32'd0);
        check_val("consumed_before_rst", 32'(exp_q.size()), 32'd6);
        arst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", all_outputs(), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        check_val("held_reset_outputs", all_outputs(), 32'd0);

        // Re-init with a request held high throughout; it is honoured only when ready.
        push_range(0, 15, 4'hF);
        i_flush_req = 1'b1; i_flush_start = 4'd2; i_flush_end = 4'd3; i_flush_mask = 4'h3;
        arst_n = 1'b1;
        accepts = 0;
        seen_ic = 1'b0;
        for (int c = 0; c < 300 && accepts < 2; c++) begin
            if (o_init_complete && !seen_ic) begin
                seen_ic = 1'b1;
                check_val("reinit_no_done", 32'(done_cnt - d0), 32'd0);
            end
            if (o_ready) begin
                $display("held request accepted start=2 end=3 mask=3");
                push_range(2, 3, 4'h3);
                accepts++;
            end
            tick();
        end
        i_flush_req = 1'b0;
        check_val("held_accepts", 32'(accepts), 32'd2);
        check_val("reinit_seen_ic", 32'(seen_ic), 32'd1);
        wait_idle("held_idle_timeout");
        tick();
        check_val("held_done_count", 32'(done_cnt - d0), 32'd2);
        check_val("reinit_complete", 32'(o_init_complete), 32'd1);
        check_val("final_ready",     32'(o_ready), 32'd1);
        check_val("final_sb_empty",  32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
